// File: rtl/can_pkg.sv
// Shared types and constants for the CAN arbitration-field receive path.
package can_pkg;

    typedef enum logic [3:0] {
        INTEG, IDLE, BASE, BIT12, IDEB, EXT, RTRX, DONE, WAIT_EOF
    } arb_state_t;

    localparam int CAN_BASE_W    = 11;
    localparam int CAN_EXT_W     = 18;
    localparam int CAN_ID_W      = 29;
    localparam int CAN_IDLE_BITS = 11;

    // Acceptance test: mask bit 1 means the ID bit is don't-care.
    function automatic logic id_match(input logic [CAN_ID_W-1:0] id,
                                      input logic [CAN_ID_W-1:0] code,
                                      input logic [CAN_ID_W-1:0] mask);
        return &(~(id ^ code) | mask);
    endfunction

endpackage

// File: rtl/can_bus_integrator.sv
// Counts consecutive recessive sample points; bus_idle once IDLE_BITS are seen.
module can_bus_integrator
    import can_pkg::*;
#(
    parameter int IDLE_BITS = CAN_IDLE_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic sp,
    input  logic rx_bit,
    input  logic enable,
    output logic bus_idle
);

    localparam int CW = $clog2(IDLE_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(IDLE_BITS);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero outside integration so each return starts a fresh run.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (sp) begin
            if (!rx_bit)           cnt_d = '0;
            else if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus_idle = (cnt_q == FULL);

endmodule

// File: rtl/can_arbitration_decoder.sv
// CAN arbitration-field decoder: SOF detect, ID/IDE/RTR capture, identifier load flag.
// Optional acceptance filter enabled by defining CAN_ACC_FILTER_EN.
module can_arbitration_decoder
    import can_pkg::*;
#(
    parameter int IDLE_BITS = CAN_IDLE_BITS,
    parameter int BASE_W    = CAN_BASE_W,
    parameter int EXT_W     = CAN_EXT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sp,
    input  logic              rx_bit,
    input  logic              stuff_bit,
    input  logic              frame_end,
    input  logic              abort,
`ifdef CAN_ACC_FILTER_EN
    input  logic [28:0]       acc_code,
    input  logic [28:0]       acc_mask,
    output logic              accept,
`endif
    output logic [BASE_W-1:0] idf,
    output logic [EXT_W-1:0]  idf_ex,
    output logic              ide,
    output logic              rtr,
    output logic              f_idf,
    output logic              arb_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(((BASE_W > EXT_W) ? BASE_W : EXT_W) + 1);
    localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(BASE_W - 1);
    localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(EXT_W - 1);

    arb_state_t        state_q, state_d;
    logic [BASE_W-1:0] idf_q, idf_d;
    logic [EXT_W-1:0]  idf_ex_q, idf_ex_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              ide_q, ide_d, rtr_q, rtr_d, tmp12_q, tmp12_d;
    logic              f_idf_q, f_idf_d, arb_done_q, arb_done_d, busy_q, busy_d;
    logic              bus_idle, bit_ev, done_ev;
`ifdef CAN_ACC_FILTER_EN
    logic              accept_q, accept_d;
`endif

    assign bit_ev = sp && !stuff_bit;

    can_bus_integrator #(.IDLE_BITS(IDLE_BITS)) u_integ (
        .clk     (clk),
        .reset   (reset),
        .sp      (sp),
        .rx_bit  (rx_bit),
        .enable  (state_q == INTEG),
        .bus_idle(bus_idle)
    );

    always_comb begin
        state_d    = state_q;
        idf_d      = idf_q;
        idf_ex_d   = idf_ex_q;
        bit_cnt_d  = bit_cnt_q;
        ide_d      = ide_q;
        rtr_d      = rtr_q;
        tmp12_d    = tmp12_q;
        f_idf_d    = f_idf_q;
        busy_d     = busy_q;
        arb_done_d = 1'b0;
        done_ev    = 1'b0;
`ifdef CAN_ACC_FILTER_EN
        accept_d   = accept_q;
`endif
        // Load flag is released by the first sample point after it dropped.
        if (!f_idf_q && sp) f_idf_d = 1'b1;

        if (abort && state_q != INTEG) begin
            state_d = INTEG;
            busy_d  = 1'b0;
            f_idf_d = 1'b1;
`ifdef CAN_ACC_FILTER_EN
            accept_d = 1'b0;
`endif
        end else begin
            case (state_q)
                INTEG: if (bus_idle) state_d = IDLE;
                IDLE: if (bit_ev && !rx_bit) begin
                    idf_d     = '0;
                    idf_ex_d  = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = BASE;
`ifdef CAN_ACC_FILTER_EN
                    accept_d  = 1'b0;
`endif
                end
                BASE: if (bit_ev) begin
                    idf_d = {idf_q[BASE_W-2:0], rx_bit};
                    if (bit_cnt_q == BASE_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = BIT12;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                BIT12: if (bit_ev) begin
                    tmp12_d = rx_bit;
                    state_d = IDEB;
                end
                IDEB: if (bit_ev) begin
                    ide_d = rx_bit;
                    if (!rx_bit) begin
                        rtr_d    = tmp12_q;
                        idf_ex_d = '0;
                        done_ev  = 1'b1;
                    end else begin
                        state_d = EXT;
                    end
                end
                EXT: if (bit_ev) begin
                    idf_ex_d = {idf_ex_q[EXT_W-2:0], rx_bit};
                    if (bit_cnt_q == EXT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = RTRX;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                RTRX: if (bit_ev) begin
                    rtr_d   = rx_bit;
                    done_ev = 1'b1;
                end
                DONE: state_d = WAIT_EOF;
                WAIT_EOF: if (frame_end) begin
                    state_d = INTEG;
                    busy_d  = 1'b0;
                end
                default: state_d = INTEG;
            endcase

            // Outputs are registered on entry so arb_done is high during DONE.
            if (done_ev) begin
                state_d    = DONE;
                arb_done_d = 1'b1;
`ifdef CAN_ACC_FILTER_EN
                accept_d   = id_match(CAN_ID_W'({idf_q, idf_ex_d}), acc_code, acc_mask);
                f_idf_d    = !accept_d;
`else
                f_idf_d    = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INTEG;
            idf_q      <= '0;
            idf_ex_q   <= '0;
            bit_cnt_q  <= '0;
            ide_q      <= 1'b0;
            rtr_q      <= 1'b0;
            tmp12_q    <= 1'b0;
            f_idf_q    <= 1'b1;
            arb_done_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef CAN_ACC_FILTER_EN
            accept_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idf_q      <= idf_d;
            idf_ex_q   <= idf_ex_d;
            bit_cnt_q  <= bit_cnt_d;
            ide_q      <= ide_d;
            rtr_q      <= rtr_d;
            tmp12_q    <= tmp12_d;
            f_idf_q    <= f_idf_d;
            arb_done_q <= arb_done_d;
            busy_q     <= busy_d;
`ifdef CAN_ACC_FILTER_EN
            accept_q   <= accept_d;
`endif
        end
    end

    assign idf      = idf_q;
    assign idf_ex   = idf_ex_q;
    assign ide      = ide_q;
    assign rtr      = rtr_q;
    assign f_idf    = f_idf_q;
    assign arb_done = arb_done_q;
    assign busy     = busy_q;
`ifdef CAN_ACC_FILTER_EN
    assign accept   = accept_q;
`endif

endmodule

// File: tb/tb_can_arbitration_decoder.sv
// Directed + randomized bench for can_arbitration_decoder against a frame-level bit model.
module tb_can_arbitration_decoder;
    import can_pkg::*;

    logic        clk = 1'b0;
    logic        reset, sp, rx_bit, stuff_bit, frame_end, abort;
    logic [10:0] idf;
    logic [17:0] idf_ex;
    logic        ide, rtr, f_idf, arb_done, busy;
`ifdef CAN_ACC_FILTER_EN
    logic [28:0] acc_code, acc_mask;
    logic        accept;
`endif

    int checks = 0, failures = 0, arb_cnt = 0;
    logic bits_q[$];
    logic stf_q[$];

    can_arbitration_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .sp       (sp),
        .rx_bit   (rx_bit),
        .stuff_bit(stuff_bit),
        .frame_end(frame_end),
        .abort    (abort),
`ifdef CAN_ACC_FILTER_EN
        .acc_code (acc_code),
        .acc_mask (acc_mask),
        .accept   (accept),
`endif
        .idf      (idf),
        .idf_ex   (idf_ex),
        .ide      (ide),
        .rtr      (rtr),
        .f_idf    (f_idf),
        .arb_done (arb_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (arb_done === 1'b1) arb_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sample point, preceded by a gap; returns 1 time unit after its edge.
    task automatic send_bit(input logic b, input logic s);
        repeat (3) @(negedge clk);
        rx_bit = b; stuff_bit = s; sp = 1'b1;
        @(posedge clk); #1;
        sp = 1'b0; stuff_bit = 1'b0;
    endtask

    task automatic integrate(input int n);
        repeat (n) send_bit(1'b1, 1'b0);
    endtask

    task automatic pulse_frame_end();
        @(negedge clk); frame_end = 1'b1;
        @(posedge clk); #1; frame_end = 1'b0;
    endtask

    // Arbitration field as transmitted, with CAN bit stuffing from SOF onward.
    task automatic build_frame(input bit ext, input logic [10:0] base, input logic [17:0] ex,
                               input bit rtrb, input bit srr);
        logic raw[$];
        logic last;
        int   run;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(base[i]);
        if (ext) begin
            raw.push_back(srr);
            raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(ex[i]);
            raw.push_back(rtrb);
        end else begin
            raw.push_back(rtrb);
            raw.push_back(1'b0);
        end
        bits_q.delete(); stf_q.delete();
        last = 1'b1; run = 0;
        foreach (raw[i]) begin
            bits_q.push_back(raw[i]); stf_q.push_back(1'b0);
            if (raw[i] == last) run++;
            else begin run = 1; last = raw[i]; end
            if (run == 5 && i != raw.size() - 1) begin
                bits_q.push_back(~raw[i]); stf_q.push_back(1'b1);
                last = ~raw[i]; run = 1;
            end
        end
    endtask

    task automatic run_frame(input bit ext, input logic [10:0] base, input logic [17:0] ex,
                             input bit rtrb, input bit srr);
        int   prev;
        logic [17:0] exp_ex;
        logic exp_f;
        exp_ex = ext ? ex : 18'h0;
`ifdef CAN_ACC_FILTER_EN
        exp_f = ~(&(~({base, exp_ex} ^ acc_code) | acc_mask));
`else
        exp_f = 1'b0;
`endif
        integrate(11);
        build_frame(ext, base, ex, rtrb, srr);
        prev = arb_cnt;
        for (int i = 0; i < bits_q.size(); i++) send_bit(bits_q[i], stf_q[i]);
        chk("arb_done_hi", arb_done, 1);
        chk("idf", idf, base);
        chk("idf_ex", idf_ex, exp_ex);
        chk("ide", ide, ext);
        chk("rtr", rtr, rtrb);
        chk("busy_frame", busy, 1);
        chk("f_idf_low", f_idf, exp_f);
`ifdef CAN_ACC_FILTER_EN
        chk("accept", accept, ~exp_f);
`endif
        @(posedge clk); #1;
        chk("arb_done_lo", arb_done, 0);
        chk("arb_once", arb_cnt - prev, 1);
        repeat (3) @(posedge clk); #1;
        chk("f_idf_hold", f_idf, exp_f);
        send_bit(1'b1, 1'b0);
        chk("f_idf_rel", f_idf, 1);
        pulse_frame_end();
        chk("busy_eof", busy, 0);
        chk("idf_stable", idf, base);
    endtask

    initial begin
        int   prev, nonstuff;
        reset = 1'b1; sp = 1'b0; rx_bit = 1'b1; stuff_bit = 1'b0;
        frame_end = 1'b0; abort = 1'b0;
`ifdef CAN_ACC_FILTER_EN
        acc_code = '0; acc_mask = '1;
`endif
        repeat (3) @(posedge clk); #1;
        chk("rst_idf", idf, 0);
        chk("rst_idf_ex", idf_ex, 0);
        chk("rst_ide", ide, 0);
        chk("rst_rtr", rtr, 0);
        chk("rst_f_idf", f_idf, 1);
        chk("rst_arb_done", arb_done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); reset = 1'b0;

        run_frame(1'b0, 11'h123, 18'h0, 1'b0, 1'b0);
        run_frame(1'b1, 11'h7A5, 18'h2AAAA, 1'b1, 1'b1);
        run_frame(1'b0, 11'h000, 18'h0, 1'b0, 1'b0);

        // Short recessive runs must not enable SOF detection.
        integrate(6);
        send_bit(1'b0, 1'b0);
        chk("no_sof_6", busy, 0);
        integrate(10);
        send_bit(1'b0, 1'b0);
        chk("no_sof_10", busy, 0);
        integrate(11);
        send_bit(1'b0, 1'b0);
        chk("sof_11", busy, 1);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_idle", busy, 0);

        // Abort inside the extended identifier.
        integrate(11);
        build_frame(1'b1, 11'h5C3, 18'h1F0F0, 1'b0, 1'b1);
        prev = arb_cnt; nonstuff = 0;
        for (int i = 0; i < bits_q.size() && nonstuff < 23; i++) begin
            send_bit(bits_q[i], stf_q[i]);
            if (!stf_q[i]) nonstuff++;
        end
        chk("pre_abort_busy", busy, 1);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_f_idf", f_idf, 1);
        chk("abort_idf_held", idf, 11'h5C3);
        integrate(4);
        chk("abort_no_arb", arb_cnt - prev, 0);
        chk("abort_f_idf2", f_idf, 1);
        run_frame(1'b1, 11'h3B2, 18'h15A5A, 1'b0, 1'b1);

        // Reset mid-frame, then a full integration is required again.
        integrate(11);
        build_frame(1'b0, 11'h5A5, 18'h0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) send_bit(bits_q[i], stf_q[i]);
        @(negedge clk); reset = 1'b1; #1;
        chk("mid_rst_idf", idf, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_f_idf", f_idf, 1);
        @(negedge clk); reset = 1'b0;
        integrate(5);
        send_bit(1'b0, 1'b0);
        chk("mid_rst_no_sof", busy, 0);

        for (int k = 0; k < 6; k++) begin
            run_frame(1'($urandom_range(0, 1)), 11'($urandom), 18'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef CAN_ACC_FILTER_EN
        acc_code = {11'h123, 18'h0}; acc_mask = '0;
        run_frame(1'b0, 11'h123, 18'h0, 1'b0, 1'b0);
        run_frame(1'b0, 11'h124, 18'h0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
